// File: rtl/gbf_fill_scheduler_if.sv
// ---------------------------------------------------------------------------
// gbf_fill_scheduler_if
// Upstream line stream shared by all GBF refill bursts.
//   src_valid  loader -> scheduler  line valid
//   src_data   loader -> scheduler  one GBF line
//   src_ready  scheduler -> loader  line accepted when src_valid && src_ready
//   src_req    scheduler -> loader  high while a burst is open
//   src_sel    scheduler -> loader  target bank: 0 actv1, 1 actv2, 2 wgt1, 3 wgt2
// master = loader side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface gbf_fill_scheduler_if #(
    parameter int unsigned DATA_BITWIDTH = 512
) ();
    logic                     src_valid;
    logic [DATA_BITWIDTH-1:0] src_data;
    logic                     src_ready;
    logic                     src_req;
    logic [1:0]               src_sel;

    modport master (
        output src_valid,
        output src_data,
        input  src_ready,
        input  src_req,
        input  src_sel
    );

    modport slave (
        input  src_valid,
        input  src_data,
        output src_ready,
        output src_req,
        output src_sel
    );
endinterface

// File: rtl/gbf_fill_scheduler.sv
// ---------------------------------------------------------------------------
// gbf_fill_scheduler
// Watches the four GBF need_data levels, arbitrates rising edges round-robin
// onto the shared upstream stream and writes each granted bank with a
// FILL_LINES burst through its port-a write interface, then flags it ready.
// Ports:
//   i_clk, i_reset               clock, synchronous active-low reset
//   src_if (slave)               upstream line stream
//   i_*_need_data                refill requests (levels), bank 0..3
//   i_finish                     stop issuing new fills
//   o_{actv,wgt}_{en,we,addr,w_data}{1,2}a   registered bank write port
//   o_gbf_*_buf*_ready           bank holds fresh data
//   o_gbf_*_data_avail           OR of the class's two ready bits
// ---------------------------------------------------------------------------
module gbf_fill_scheduler #(
    parameter int unsigned GBF_DATA_BITWIDTH = 512,
    parameter int unsigned GBF_ADDR_BITWIDTH = 5,
    parameter int unsigned GBF_DEPTH         = 32,
    parameter int unsigned FILL_LINES        = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    gbf_fill_scheduler_if.slave          src_if,
    input  logic                         i_actv_gbf1_need_data,
    input  logic                         i_actv_gbf2_need_data,
    input  logic                         i_wgt_gbf1_need_data,
    input  logic                         i_wgt_gbf2_need_data,
    input  logic                         i_finish,
    output logic                         o_actv_en1a,
    output logic                         o_actv_we1a,
    output logic [GBF_ADDR_BITWIDTH-1:0] o_actv_addr1a,
    output logic [GBF_DATA_BITWIDTH-1:0] o_actv_w_data1a,
    output logic                         o_actv_en2a,
    output logic                         o_actv_we2a,
    output logic [GBF_ADDR_BITWIDTH-1:0] o_actv_addr2a,
    output logic [GBF_DATA_BITWIDTH-1:0] o_actv_w_data2a,
    output logic                         o_wgt_en1a,
    output logic                         o_wgt_we1a,
    output logic [GBF_ADDR_BITWIDTH-1:0] o_wgt_addr1a,
    output logic [GBF_DATA_BITWIDTH-1:0] o_wgt_w_data1a,
    output logic                         o_wgt_en2a,
    output logic                         o_wgt_we2a,
    output logic [GBF_ADDR_BITWIDTH-1:0] o_wgt_addr2a,
    output logic [GBF_DATA_BITWIDTH-1:0] o_wgt_w_data2a,
    output logic                         o_gbf_actv_buf1_ready,
    output logic                         o_gbf_actv_buf2_ready,
    output logic                         o_gbf_wgt_buf1_ready,
    output logic                         o_gbf_wgt_buf2_ready,
    output logic                         o_gbf_actv_data_avail,
    output logic                         o_gbf_wgt_data_avail
);

    if (FILL_LINES < 1 || FILL_LINES > GBF_DEPTH) begin : g_param_check
        $error("FILL_LINES must lie within 1..GBF_DEPTH");
    end

    localparam logic [GBF_ADDR_BITWIDTH-1:0] LastBeat = GBF_ADDR_BITWIDTH'(FILL_LINES - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDoneFill, StHalt} state_e;

    state_e                       r_state;
    logic [1:0]                   r_sel;
    logic [1:0]                   r_rr_ptr;
    logic [GBF_ADDR_BITWIDTH-1:0] r_beat_cnt;
    logic [3:0]                   r_prev;
    logic [3:0]                   r_pending;
    logic [3:0]                   r_ready;
    logic [3:0]                   r_wr_en;
    logic [GBF_ADDR_BITWIDTH-1:0] r_addr [4];
    logic [GBF_DATA_BITWIDTH-1:0] r_data [4];

    logic [3:0] w_need;
    logic [3:0] w_rise;
    logic [3:0] w_rot;
    logic [1:0] w_offset;
    logic [1:0] w_grant_idx;
    logic       w_grant;
    logic [3:0] w_grant_mask;
    logic [3:0] w_done_mask;
    logic       w_filling;

    assign w_need = {i_wgt_gbf2_need_data, i_wgt_gbf1_need_data,
                     i_actv_gbf2_need_data, i_actv_gbf1_need_data};
    assign w_rise = w_need & ~r_prev;

    // Rotate pending so bit 0 is the bank at rr_ptr; the lowest set bit wins.
    assign w_rot = 4'({r_pending, r_pending} >> r_rr_ptr);

    always_comb begin
        w_offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_rot[i]) w_offset = 2'(i);
        end
    end

    assign w_grant_idx  = r_rr_ptr + w_offset;
    assign w_grant      = (r_state == StIdle) && !i_finish && (|r_pending);
    assign w_grant_mask = w_grant ? (4'b0001 << w_grant_idx) : 4'b0000;
    assign w_done_mask  = (r_state == StDoneFill) ? (4'b0001 << r_sel) : 4'b0000;
    assign w_filling    = (r_state == StFill);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_sel      <= 2'd0;
            r_rr_ptr   <= 2'd0;
            r_beat_cnt <= '0;
            r_prev     <= '0;
            r_pending  <= '0;
            r_ready    <= '0;
            r_wr_en    <= '0;
            for (int b = 0; b < 4; b++) begin
                r_addr[b] <= '0;
                r_data[b] <= '0;
            end
        end else begin
            r_prev    <= w_need;
            // A new edge always re-arms, even on the bank just granted.
            r_pending <= (r_pending & ~w_grant_mask) | w_rise;
            // Completion beats a coincident edge on the same bank.
            r_ready   <= (r_ready & ~w_rise) | w_done_mask;
            r_wr_en   <= '0;
            case (r_state)
                StIdle: begin
                    if (i_finish) begin
                        r_state <= StHalt;
                    end else if (w_grant) begin
                        r_sel      <= w_grant_idx;
                        r_rr_ptr   <= w_grant_idx + 2'd1;
                        r_beat_cnt <= '0;
                        r_state    <= StFill;
                    end
                end
                StFill: begin
                    if (src_if.src_valid) begin
                        r_wr_en       <= 4'b0001 << r_sel;
                        r_addr[r_sel] <= r_beat_cnt;
                        r_data[r_sel] <= src_if.src_data;
                        if (r_beat_cnt == LastBeat) begin
                            r_beat_cnt <= '0;
                            r_state    <= StDoneFill;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + GBF_ADDR_BITWIDTH'(1);
                        end
                    end
                end
                StDoneFill: r_state <= i_finish ? StHalt : StIdle;
                StHalt: begin
                    if (!i_finish) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign src_if.src_ready = w_filling;
    assign src_if.src_req   = w_filling;
    assign src_if.src_sel   = r_sel;

    assign o_actv_en1a     = r_wr_en[0];
    assign o_actv_we1a     = r_wr_en[0];
    assign o_actv_addr1a   = r_addr[0];
    assign o_actv_w_data1a = r_data[0];
    assign o_actv_en2a     = r_wr_en[1];
    assign o_actv_we2a     = r_wr_en[1];
    assign o_actv_addr2a   = r_addr[1];
    assign o_actv_w_data2a = r_data[1];
    assign o_wgt_en1a      = r_wr_en[2];
    assign o_wgt_we1a      = r_wr_en[2];
    assign o_wgt_addr1a    = r_addr[2];
    assign o_wgt_w_data1a  = r_data[2];
    assign o_wgt_en2a      = r_wr_en[3];
    assign o_wgt_we2a      = r_wr_en[3];
    assign o_wgt_addr2a    = r_addr[3];
    assign o_wgt_w_data2a  = r_data[3];

    assign o_gbf_actv_buf1_ready = r_ready[0];
    assign o_gbf_actv_buf2_ready = r_ready[1];
    assign o_gbf_wgt_buf1_ready  = r_ready[2];
    assign o_gbf_wgt_buf2_ready  = r_ready[3];
    assign o_gbf_actv_data_avail = r_ready[0] | r_ready[1];
    assign o_gbf_wgt_data_avail  = r_ready[2] | r_ready[3];

endmodule

// File: tb/tb_gbf_fill_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gbf_fill_scheduler
// Self-checking bench: every cycle the DUT outputs are compared against a
// bank-level reference model; table vectors and hand sequences add
// targeted checks on ordering, latency and corner cases.
// ---------------------------------------------------------------------------
module tb_gbf_fill_scheduler;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;
    localparam int          FL = 32;
    localparam int unsigned VW = 294;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] need   = 4'b0000;
    logic       finish = 1'b0;

    always #5 clk = ~clk;

    gbf_fill_scheduler_if #(.DATA_BITWIDTH(DW)) src_if ();

    logic          a_en1, a_we1, a_en2, a_we2, g_en1, g_we1, g_en2, g_we2;
    logic [AW-1:0] a_addr1, a_addr2, g_addr1, g_addr2;
    logic [DW-1:0] a_dat1, a_dat2, g_dat1, g_dat2;
    logic          a_rdy1, a_rdy2, g_rdy1, g_rdy2, a_avail, g_avail;

    gbf_fill_scheduler #(
        .GBF_DATA_BITWIDTH(DW),
        .GBF_ADDR_BITWIDTH(AW),
        .GBF_DEPTH        (32),
        .FILL_LINES       (FL)
    ) dut (
        .i_clk                (clk),
        .i_reset              (rst_n),
        .src_if               (src_if),
        .i_actv_gbf1_need_data(need[0]),
        .i_actv_gbf2_need_data(need[1]),
        .i_wgt_gbf1_need_data (need[2]),
        .i_wgt_gbf2_need_data (need[3]),
        .i_finish             (finish),
        .o_actv_en1a          (a_en1),
        .o_actv_we1a          (a_we1),
        .o_actv_addr1a        (a_addr1),
        .o_actv_w_data1a      (a_dat1),
        .o_actv_en2a          (a_en2),
        .o_actv_we2a          (a_we2),
        .o_actv_addr2a        (a_addr2),
        .o_actv_w_data2a      (a_dat2),
        .o_wgt_en1a           (g_en1),
        .o_wgt_we1a           (g_we1),
        .o_wgt_addr1a         (g_addr1),
        .o_wgt_w_data1a       (g_dat1),
        .o_wgt_en2a           (g_en2),
        .o_wgt_we2a           (g_we2),
        .o_wgt_addr2a         (g_addr2),
        .o_wgt_w_data2a       (g_dat2),
        .o_gbf_actv_buf1_ready(a_rdy1),
        .o_gbf_actv_buf2_ready(a_rdy2),
        .o_gbf_wgt_buf1_ready (g_rdy1),
        .o_gbf_wgt_buf2_ready (g_rdy2),
        .o_gbf_actv_data_avail(a_avail),
        .o_gbf_wgt_data_avail (g_avail)
    );

    logic [3:0] d_en, d_we, d_ready;
    logic [1:0] d_avail;
    assign d_en    = {g_en2, g_en1, a_en2, a_en1};
    assign d_we    = {g_we2, g_we1, a_we2, a_we1};
    assign d_ready = {g_rdy2, g_rdy1, a_rdy2, a_rdy1};
    assign d_avail = {g_avail, a_avail};

    function automatic logic [AW-1:0] d_addr(input int b);
        case (b)
            0: return a_addr1;
            1: return a_addr2;
            2: return g_addr1;
            default: return g_addr2;
        endcase
    endfunction

    function automatic logic [DW-1:0] d_data(input int b);
        case (b)
            0: return a_dat1;
            1: return a_dat2;
            2: return g_dat1;
            default: return g_dat2;
        endcase
    endfunction

    // ---------------- reference model (bank-level view) ----------------
    logic [3:0]    m_prev, m_pend, m_ready, m_en;
    logic [1:0]    m_sel;
    int            m_bank;     // bank being filled, -1 when none
    int            m_beats;    // beats accepted in current burst
    int            m_rr;       // first bank to consider next
    bit            m_done;     // burst complete, one wrap-up cycle pending
    bit            m_halted;
    logic [AW-1:0] m_addr [4];
    logic [DW-1:0] m_data [4];

    task automatic model_update();
        logic [3:0] rise, setr, clrp;
        int wr;
        if (!rst_n) begin
            m_prev = '0; m_pend = '0; m_ready = '0; m_en = '0; m_sel = '0;
            m_bank = -1; m_beats = 0; m_rr = 0; m_done = 0; m_halted = 0;
            for (int i = 0; i < 4; i++) begin
                m_addr[i] = '0;
                m_data[i] = '0;
            end
            return;
        end
        rise = need & ~m_prev;
        setr = '0;
        clrp = '0;
        wr   = -1;
        if (m_done) begin
            setr[m_bank] = 1'b1;
            m_bank   = -1;
            m_done   = 0;
            m_halted = finish;
        end else if (m_bank >= 0) begin
            if (src_if.src_valid) begin
                wr = m_bank;
                m_addr[m_bank] = AW'(m_beats);
                m_data[m_bank] = src_if.src_data;
                m_beats++;
                if (m_beats == FL) m_done = 1;
            end
        end else if (m_halted) begin
            if (!finish) m_halted = 0;
        end else if (finish) begin
            m_halted = 1;
        end else if (m_pend != 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_bank < 0 && m_pend[(m_rr + k) % 4]) m_bank = (m_rr + k) % 4;
            end
            m_sel        = 2'(m_bank);
            m_beats      = 0;
            m_rr         = (m_bank + 1) % 4;
            clrp[m_bank] = 1'b1;
        end
        m_pend  = (m_pend & ~clrp) | rise;
        m_ready = (m_ready & ~rise) | setr;
        m_prev  = need;
        m_en    = (wr >= 0) ? 4'(1 << wr) : 4'b0000;
    endtask

    function automatic logic [VW-1:0] got_vec();
        return {d_ready, d_avail, d_en, d_we, src_if.src_req, src_if.src_ready, src_if.src_sel,
                d_addr(3), d_addr(2), d_addr(1), d_addr(0),
                d_data(3), d_data(2), d_data(1), d_data(0)};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic busy;
        busy = (m_bank >= 0) && !m_done;
        return {m_ready, m_ready[3] | m_ready[2], m_ready[1] | m_ready[0], m_en, m_en,
                busy, busy, m_sel, m_addr[3], m_addr[2], m_addr[1], m_addr[0],
                m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    // ---------------- checking infrastructure ----------------
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rand_data = 0;
    int            wlog_bank [$];
    int            wlog_addr [$];
    logic [DW-1:0] wlog_data [$];

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic clear_log();
        wlog_bank.delete();
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        check("cycle", got_vec(), exp_vec());
        for (int b = 0; b < 4; b++) begin
            if (d_en[b]) begin
                wlog_bank.push_back(b);
                wlog_addr.push_back(int'(d_addr(b)));
                wlog_data.push_back(d_data(b));
            end
        end
        if (rand_data) src_if.src_data = {$urandom, $urandom};
        else           src_if.src_data = DW'(m_beats);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        need  = '0;
        finish = 1'b0;
        src_if.src_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic wait_ready(input string name, input logic [3:0] mask, input int limit,
                              output int edges);
        edges = 0;
        while ((d_ready & mask) != mask && edges < limit) begin
            step();
            edges++;
        end
        check(name, VW'(d_ready & mask), VW'(mask));
    endtask

    task automatic wait_writes(input int n, input int limit);
        int e = 0;
        while (wlog_bank.size() < n && e < limit) begin
            step();
            e++;
        end
        check("wait_writes", VW'(wlog_bank.size() >= n), VW'(1));
    endtask

    function automatic int count_bank(input int b);
        int c = 0;
        foreach (wlog_bank[i]) if (wlog_bank[i] == b) c++;
        return c;
    endfunction

    // Writes must come as whole bursts in ascending bank order, addr 0..FL-1, data = addr.
    function automatic int seq_bad(input logic [3:0] banks);
        int eb[$];
        int bad = 0;
        for (int b = 0; b < 4; b++) if (banks[b]) eb.push_back(b);
        foreach (wlog_bank[i]) begin
            if (i / FL >= eb.size()) bad++;
            else if (wlog_bank[i] != eb[i / FL] || wlog_addr[i] != i % FL ||
                     wlog_data[i] != DW'(i % FL)) bad++;
        end
        return bad;
    endfunction

    typedef struct {
        logic [3:0] need;
        logic [1:0] exp_avail;
        int         exp_edges;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int e;
        src_if.src_valid = 1'b0;
        src_if.src_data  = '0;

        vecs[0] = '{4'b0001, 2'b01, 35};
        vecs[1] = '{4'b0010, 2'b01, 35};
        vecs[2] = '{4'b0100, 2'b10, 35};
        vecs[3] = '{4'b1000, 2'b10, 35};
        vecs[4] = '{4'b0011, 2'b01, 69};
        vecs[5] = '{4'b1100, 2'b10, 69};
        vecs[6] = '{4'b0101, 2'b11, 69};
        vecs[7] = '{4'b1111, 2'b11, 137};

        do_reset();
        check("reset_state", got_vec(), '0);

        // Table: requests raised together, source always valid.
        foreach (vecs[v]) begin
            do_reset();
            src_if.src_valid = 1'b1;
            need = vecs[v].need;
            wait_ready("vec_ready", vecs[v].need, 300, e);
            check("vec_edges", VW'(e), VW'(vecs[v].exp_edges));
            check("vec_avail", VW'(d_avail), VW'(vecs[v].exp_avail));
            check("vec_nwrites", VW'(wlog_bank.size()), VW'(FL * $countones(vecs[v].need)));
            check("vec_order", VW'(seq_bad(vecs[v].need)), '0);
        end

        // No request: nothing happens.
        do_reset();
        src_if.src_valid = 1'b1;
        repeat (40) step();
        check("idle_nwrites", VW'(wlog_bank.size()), '0);
        check("idle_ready", VW'(d_ready), '0);

        // Round-robin continues from rr_ptr=0 after wgt2: actv1 before wgt2.
        need = 4'b1111;
        wait_ready("rr_first", 4'b1111, 300, e);
        need = 4'b0000;
        step();
        step();
        clear_log();
        need = 4'b1001;
        step();
        check("rr_ready_cleared", VW'(d_ready), VW'(4'b0110));
        wait_ready("rr_second", 4'b1001, 300, e);
        check("rr_nwrites", VW'(wlog_bank.size()), VW'(2 * FL));
        check("rr_order", VW'(seq_bad(4'b1001)), '0);

        // Re-request on wgt2: ready clears one cycle after the edge, second fill follows.
        need = 4'b0001;
        step();
        check("rereq_still_ready", VW'(d_ready[3]), VW'(1));
        clear_log();
        need = 4'b1001;
        step();
        check("rereq_clear", VW'(d_ready[3]), VW'(0));
        wait_ready("rereq_fill", 4'b1000, 100, e);
        check("rereq_nwrites", VW'(count_bank(3)), VW'(FL));

        // Backpressure: src_valid toggles every cycle.
        do_reset();
        need = 4'b0001;
        e = 0;
        while (d_ready[0] != 1'b1 && e < 300) begin
            src_if.src_valid = ~src_if.src_valid;
            step();
            e++;
        end
        check("bp_ready", VW'(d_ready[0]), VW'(1));
        check("bp_nwrites", VW'(wlog_bank.size()), VW'(FL));
        check("bp_seq", VW'(seq_bad(4'b0001)), '0);

        // finish mid-fill of actv2 while wgt1 pends.
        do_reset();
        src_if.src_valid = 1'b1;
        need = 4'b0010;
        repeat (3) step();
        need = 4'b0110;
        wait_writes(10, 100);
        finish = 1'b1;
        wait_ready("fin_actv2_ready", 4'b0010, 100, e);
        repeat (40) step();
        check("fin_no_wgt1", VW'(count_bank(2)), '0);
        check("fin_wgt1_not_ready", VW'(d_ready[2]), '0);
        check("fin_actv2_nwrites", VW'(count_bank(1)), VW'(FL));
        finish = 1'b0;
        wait_ready("fin_wgt1_ready", 4'b0100, 100, e);
        check("fin_wgt1_nwrites", VW'(count_bank(2)), VW'(FL));

        // Reset at beat 5 abandons the fill; the held level restarts it from addr 0.
        do_reset();
        src_if.src_valid = 1'b1;
        need = 4'b0001;
        wait_writes(5, 100);
        rst_n = 1'b0;
        step();
        check("rst_outputs_zero", got_vec(), '0);
        rst_n = 1'b1;
        clear_log();
        wait_ready("rst_restart", 4'b0001, 100, e);
        check("rst_restart_edges", VW'(e), VW'(35));
        check("rst_restart_seq", VW'(seq_bad(4'b0001)), '0);

        // Randomized traffic against the model.
        do_reset();
        rand_data = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) need = need ^ (4'b0001 << $urandom_range(0, 3));
            src_if.src_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) finish = ~finish;
            rst_n = ($urandom_range(0, 599) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
